// File: rtl/mcycle_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mcycle_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTING,
    DONE
  } state_t;

endpackage

// File: rtl/mcycle_abs_neg.sv
// Conditional two's-complement of an N-bit word: result = en ? -value : value.
module mcycle_abs_neg
  import mcycle_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] value,
  input  logic         en,
  output logic [N-1:0] result
);

  assign result = en ? (~value + 1'b1) : value;

endmodule

// File: rtl/mcycle_unit.sv
// Radix-2 iterative multiply/divide unit, one bit per cycle, stalls the PC via Busy.
// Divide datapath is built only when MCYCLE_DIV_EN is defined.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hi_q, lo_q, mag_b_q;
  logic             neg_q;
  logic             op_ok, start_ok, last_iter;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic [WIDTH-1:0] final_r1, final_r2;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_fixed;

`ifdef MCYCLE_DIV_EN
  logic             op_q, neg_rem_q, divzero_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] div_hi, div_lo, quo_fixed, rem_fixed;
  assign op_ok = 1'b1;
`else
  assign op_ok = (MCycleOp == OP_MUL);
`endif

  assign start_ok  = Start & op_ok;
  assign last_iter = (state == COMPUTING) && (count_q == CW'(WIDTH-1));

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    case (state)
      IDLE: begin
        Busy = start_ok;
        if (start_ok) state_next = COMPUTING;
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  mcycle_abs_neg #(.N(WIDTH)) u_abs1 (.value(Operand1), .en(Signed & Operand1[WIDTH-1]), .result(mag1));
  mcycle_abs_neg #(.N(WIDTH)) u_abs2 (.value(Operand2), .en(Signed & Operand2[WIDTH-1]), .result(mag2));

  // Shift-add step: hi:lo shifts right, adding the multiplicand when the multiplier LSB is set.
  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);

`ifdef MCYCLE_DIV_EN
  // Restoring step: the remainder, widened by one bit, absorbs the next dividend bit.
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mag_b_q};
  assign div_hi  = ge ? (shifted[WIDTH-1:0] - mag_b_q) : shifted[WIDTH-1:0];
  assign div_lo  = {lo_q[WIDTH-2:0], ge};
  assign iter_hi = (op_q == OP_DIV) ? div_hi : add_sum[WIDTH:1];
  assign iter_lo = (op_q == OP_DIV) ? div_lo : {add_sum[0], lo_q[WIDTH-1:1]};
`else
  assign iter_hi = add_sum[WIDTH:1];
  assign iter_lo = {add_sum[0], lo_q[WIDTH-1:1]};
`endif

  mcycle_abs_neg #(.N(2*WIDTH)) u_prod_fix (.value({iter_hi, iter_lo}), .en(neg_q), .result(prod_fixed));

`ifdef MCYCLE_DIV_EN
  mcycle_abs_neg #(.N(WIDTH)) u_quo_fix (.value(iter_lo), .en(neg_q),     .result(quo_fixed));
  mcycle_abs_neg #(.N(WIDTH)) u_rem_fix (.value(iter_hi), .en(neg_rem_q), .result(rem_fixed));

  always_comb begin
    final_r1 = prod_fixed[WIDTH-1:0];
    final_r2 = prod_fixed[2*WIDTH-1:WIDTH];
    if (op_q == OP_DIV) begin
      // Divide-by-zero returns the raw dividend and overrides any sign fix.
      if (divzero_q) begin
        final_r1 = '1;
        final_r2 = dividend_q;
      end else begin
        final_r1 = quo_fixed;
        final_r2 = rem_fixed;
      end
    end
  end
`else
  assign final_r1 = prod_fixed[WIDTH-1:0];
  assign final_r2 = prod_fixed[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
`ifdef MCYCLE_DIV_EN
      op_q       <= OP_MUL;
      neg_rem_q  <= 1'b0;
      divzero_q  <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          count_q <= '0;
          hi_q    <= '0;
          lo_q    <= (MCycleOp == OP_DIV) ? mag1 : mag2;
          mag_b_q <= (MCycleOp == OP_DIV) ? mag2 : mag1;
          neg_q   <= Signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
          op_q       <= MCycleOp;
          neg_rem_q  <= Signed & Operand1[WIDTH-1];
          divzero_q  <= (Operand2 == '0);
          dividend_q <= Operand1;
`endif
        end
        COMPUTING: begin
          hi_q    <= iter_hi;
          lo_q    <= iter_lo;
          count_q <= count_q + 1'b1;
          if (last_iter) begin
            Result1 <= final_r1;
            Result2 <= final_r2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: expected results queued at issue, popped when Busy falls.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         Reset, Start, MCycleOp, Signed;
  logic [W-1:0] Operand1, Operand2, Result1, Result2;
  logic         Busy;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_r1 = '0;
  logic [W-1:0] last_r2 = '0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp), .Signed(Signed),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    int          da, db;
    if (op == OP_MUL) begin
      if (sgn) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      else     p = {32'b0, a} * {32'b0, b};
      e.r1 = p[31:0];
      e.r2 = p[63:32];
    end else if (b == '0) begin
      e.r1 = '1;
      e.r2 = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.r1 = 32'h8000_0000;
      e.r2 = '0;
    end else if (sgn) begin
      da   = a;
      db   = b;
      e.r1 = da / db;
      e.r2 = da % db;
    end else begin
      e.r1 = a / b;
      e.r2 = a % b;
    end
    return e;
  endfunction

  // Counts Busy-high cycles from the current sample point; operands are scrambled mid-run.
  task automatic wait_busy_end(output int len);
    len = 0;
    while (Busy === 1'b1 && len < 200) begin
      len++;
      if (len == 2) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic finish_op(input string tag);
    int   len;
    exp_t e;
    wait_busy_end(len);
    check({tag, "_busy_len"}, 64'(len), 64'(W + 1));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_r1"}, 64'(Result1), 64'(e.r1));
      check({tag, "_r2"}, 64'(Result2), 64'(e.r2));
      last_r1 = e.r1;
      last_r2 = e.r2;
    end
    // Start stays high through DONE; it must not retrigger.
    @(negedge CLK);
    Start = 1'b0;
    #1;
    check({tag, "_no_retrigger"}, 64'(Busy), 64'd0);
    repeat (2) @(negedge CLK);
    #1;
    check({tag, "_hold"}, {Result2, Result1}, {last_r2, last_r1});
  endtask

  task automatic run_op(input string tag, input logic op, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(op, sgn, a, b));
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = op;
    Signed   = sgn;
    Operand1 = a;
    Operand2 = b;
    #1;
    finish_op(tag);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MCycleOp = OP_MUL; Signed = 1'b0;
    Operand1 = '0; Operand2 = '0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_results", {Result2, Result1}, 64'd0);

    run_op("mul_u_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_s_m3x7", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
    run_op("mul_s_minxmin", OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op("mul_s_minxm1", OP_MUL, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mul_zero", OP_MUL, 1'b1, 32'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++)
      run_op($sformatf("mul_rand%0d", i), OP_MUL, 1'($urandom_range(1)), $urandom, $urandom);

    // Reset at COMPUTING count 10 with Start still high: abort, then a fresh run.
    sb.push_back(model(OP_MUL, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
    @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_MUL; Signed = 1'b0;
    Operand1 = 32'h1234_5678; Operand2 = 32'h9ABC_DEF0;
    repeat (11) @(negedge CLK);
    #1;
    check("abort_busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("abort_results_zero", {Result2, Result1}, 64'd0);
    finish_op("abort_restart");

`ifdef MCYCLE_DIV_EN
    run_op("div_s_m7d2", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div_s_ovf", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_u_by0", OP_DIV, 1'b0, 32'd100, 32'd0);
    run_op("div_s_by0", OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0);
    run_op("div_u_big", OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd3);
    run_op("div_s_7dm2", OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++)
      run_op($sformatf("div_rand%0d", i), OP_DIV, 1'($urandom_range(1)), $urandom,
             32'($urandom_range(1, 5000)));
`else
    @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_DIV; Signed = 1'b1;
    Operand1 = 32'hFFFF_FFF9; Operand2 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("div_off_busy%0d", i), 64'(Busy), 64'd0);
      check($sformatf("div_off_hold%0d", i), {Result2, Result1}, {last_r2, last_r1});
      @(negedge CLK);
    end
    Start = 1'b0;
    run_op("mul_after_div_off", OP_MUL, 1'b0, 32'd12345, 32'd6789);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
